// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath and the digit-setting FSM.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CH_HUND   = 3'd1,
      CH_TENTHS = 3'd2,
      CH_SEC    = 3'd3,
      CH_TEN    = 3'd4
   } state_e;

   localparam int DIGIT_W       = 4;
   localparam int PULSE_MAX_DEF = 999_999;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit: mod-10 counter with clear priority and a carry-out.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               en_i,
   input  logic               clr_i,
   output logic [DIGIT_W-1:0] value_o,
   output logic               carry_o
);

   logic [DIGIT_W-1:0] value_q;
   logic [DIGIT_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = '0;
      end else if (en_i) begin
         value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;
   assign carry_o = en_i && (value_q == 4'd9);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping datapath: 10 ms prescaler, run control and
// four chained BCD digits with direct per-digit setting while stopped.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int PULSE_MAX = PULSE_MAX_DEF
) (
   input  logic               clk100_i,
   input  logic               rstn_i,
   input  logic               start_stop_i,
   input  logic               clear_i,
   input  logic [2:0]         state_value_i,
   input  logic               increm_i,
   output logic               device_running_o,
   output logic [DIGIT_W-1:0] hund_o,
   output logic [DIGIT_W-1:0] tenths_o,
   output logic [DIGIT_W-1:0] sec_o,
   output logic [DIGIT_W-1:0] ten_o
);

   localparam int PW = (PULSE_MAX > 0) ? $clog2(PULSE_MAX + 1) : 1;

   logic          running_q;
   logic          running_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic          tick;
   logic          inc;
   logic          clr;
   logic [3:0]    sel;
   logic [3:0]    en;
   logic [3:0]    carry;

   assign tick = running_q && (presc_q == PW'(PULSE_MAX));
   assign inc  = increm_i && !running_q;
   assign clr  = clear_i && !running_q;

   always_comb begin
      sel = 4'b0000;
      case (state_value_i)
         CH_HUND:   sel = 4'b0001;
         CH_TENTHS: sel = 4'b0010;
         CH_SEC:    sel = 4'b0100;
         CH_TEN:    sel = 4'b1000;
         default:   sel = 4'b0000;
      endcase
   end

   always_comb begin
      running_d = running_q ^ start_stop_i;
      presc_d   = '0;
      if (running_q && !tick) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
         running_q <= 1'b0;
         presc_q   <= '0;
      end else begin
         running_q <= running_d;
         presc_q   <= presc_d;
      end
   end

   // Carries only propagate on a tick, so setting a 9 never ripples.
   assign en[0] = tick || (inc && sel[0]);
   assign en[1] = (tick && carry[0]) || (inc && sel[1]);
   assign en[2] = (tick && carry[1]) || (inc && sel[2]);
   assign en[3] = (tick && carry[2]) || (inc && sel[3]);

   bcd_digit u_hund (
      .clk_i   (clk100_i),
      .rstn_i  (rstn_i),
      .en_i    (en[0]),
      .clr_i   (clr),
      .value_o (hund_o),
      .carry_o (carry[0])
   );

   bcd_digit u_tenths (
      .clk_i   (clk100_i),
      .rstn_i  (rstn_i),
      .en_i    (en[1]),
      .clr_i   (clr),
      .value_o (tenths_o),
      .carry_o (carry[1])
   );

   bcd_digit u_sec (
      .clk_i   (clk100_i),
      .rstn_i  (rstn_i),
      .en_i    (en[2]),
      .clr_i   (clr),
      .value_o (sec_o),
      .carry_o (carry[2])
   );

   bcd_digit u_ten (
      .clk_i   (clk100_i),
      .rstn_i  (rstn_i),
      .en_i    (en[3]),
      .clr_i   (clr),
      .value_o (ten_o),
      .carry_o (carry[3])
   );

   assign device_running_o = running_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised and directed bench for stopwatch_core against a
// centisecond-arithmetic reference model.
module tb_stopwatch_core;

   localparam int PM = 3;

   logic       clk;
   logic       rstn;
   logic       start_stop;
   logic       clear;
   logic [2:0] state_value;
   logic       increm;
   logic       running;
   logic [3:0] hund;
   logic [3:0] tenths;
   logic [3:0] sec;
   logic [3:0] ten;

   int vectors;
   int miscompares;

   int m_d[4];
   int m_run;
   int m_phase;

   stopwatch_core #(.PULSE_MAX(PM)) dut (
      .clk100_i         (clk),
      .rstn_i           (rstn),
      .start_stop_i     (start_stop),
      .clear_i          (clear),
      .state_value_i    (state_value),
      .increm_i         (increm),
      .device_running_o (running),
      .hund_o           (hund),
      .tenths_o         (tenths),
      .sec_o            (sec),
      .ten_o            (ten)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_d[i] = 0;
      m_run   = 0;
      m_phase = 0;
   endtask

   task automatic model_edge(input logic s, input logic c,
                             input logic [2:0] st, input logic inc);
      int total;
      bit tick;
      tick  = (m_run != 0) && (m_phase == PM);
      total = m_d[3] * 1000 + m_d[2] * 100 + m_d[1] * 10 + m_d[0];
      if (tick) begin
         total = (total + 1) % 10000;
         m_d[0] = total % 10;
         m_d[1] = (total / 10) % 10;
         m_d[2] = (total / 100) % 10;
         m_d[3] = total / 1000;
      end
      if (m_run == 0) begin
         if (c) begin
            for (int i = 0; i < 4; i++) m_d[i] = 0;
         end else if (inc && st >= 3'd1 && st <= 3'd4) begin
            m_d[st - 1] = (m_d[st - 1] + 1) % 10;
         end
      end
      m_phase = ((m_run != 0) && !tick) ? m_phase + 1 : 0;
      if (s) m_run = (m_run != 0) ? 0 : 1;
   endtask

   task automatic check(input string tag);
      logic [16:0] obs;
      logic [16:0] exp;
      obs = {running, ten, sec, tenths, hund};
      exp = {m_run[0], m_d[3][3:0], m_d[2][3:0],
             m_d[1][3:0], m_d[0][3:0]};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic s, input logic c,
                       input logic [2:0] st, input logic inc,
                       input string tag);
      start_stop  = s;
      clear       = c;
      state_value = st;
      increm      = inc;
      @(posedge clk);
      model_edge(s, c, st, inc);
      #1;
      check(tag);
      start_stop = 1'b0;
      clear      = 1'b0;
      increm     = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, tag);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      start_stop  = 1'b0;
      clear       = 1'b0;
      state_value = 3'd0;
      increm      = 1'b0;
      model_reset();
      #12;
      check("reset");
      rstn = 1'b1;
      @(negedge clk);

      step(1, 0, 3'd0, 0, "start");
      idle(40, "count40");
      step(1, 0, 3'd0, 0, "stop");
      step(0, 1, 3'd0, 0, "clear");

      for (int d = 1; d <= 4; d++)
         for (int k = 0; k < 9; k++)
            step(0, 0, 3'(d), 1, "preload");
      step(1, 0, 3'd0, 0, "start_9999");
      idle(4, "wrap");
      step(1, 0, 3'd0, 0, "stop_wrap");

      for (int k = 0; k < 10; k++) step(0, 0, 3'd3, 1, "sec_inc");
      step(0, 0, 3'd1, 1, "hund_inc");
      for (int k = 0; k < 9; k++) step(0, 0, 3'd1, 1, "hund_nocarry");

      step(1, 0, 3'd2, 1, "start_inc");
      step(0, 0, 3'd2, 1, "run_inc");
      step(0, 1, 3'd0, 0, "run_clear");
      idle(2, "run");
      step(1, 0, 3'd0, 0, "stop_at_tick");
      step(0, 0, 3'd0, 1, "inc_idle");
      step(0, 0, 3'd6, 1, "inc_inval");
      step(0, 0, 3'd7, 1, "inc_inval7");
      step(0, 1, 3'd1, 1, "clear_inc");

      for (int k = 0; k < 400; k++)
         step(($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
              3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
              "random");

      step(0, 0, 3'd2, 1, "pre_rst");
      if (m_run == 0) step(1, 0, 3'd0, 0, "pre_rst_start");
      idle(6, "pre_rst_run");
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      #1;
      step(1, 0, 3'd0, 0, "post_rst_start");
      idle(12, "post_rst_run");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping datapath of the lab stopwatch, directly downstream of the digit-setting state machine. Holds four BCD digits (tens of seconds, seconds, tenths, hundredths) and advances them at 100 Hz while running. While stopped, it increments the digit selected by the setting FSM on each single-cycle increment pulse. It drives `device_running_o` back to the FSM and feeds the digits to the display stage.

## Interface
- `PULSE_MAX`, default 999_999 — terminal count of the 10 ms prescaler; period = PULSE_MAX+1 cycles of `clk100_i`.
- `clk100_i` in 1 — 100 MHz system clock.
- `rstn_i` in 1 — reset; one clock domain; asynchronous, active-low.
- `start_stop_i` in 1 — single-cycle pulse, synchronised and edge-detected upstream; toggles running.
- `clear_i` in 1 — single-cycle pulse; zeroes all digits when stopped.
- `state_value_i` in 3 — setting-FSM state: 0 IDLE, 1 hundredths, 2 tenths, 3 seconds, 4 tens; 5–7 invalid.
- `increm_i` in 1 — single-cycle pulse from the FSM; increments the selected digit.
- `device_running_o` out 1 — 1 while counting.
- `hund_o`, `tenths_o`, `sec_o`, `ten_o` out 4 each — BCD digits, each 0–9.

## Operation
- Reset: `device_running_o`=0, all digits 0, prescaler 0.
- `start_stop_i`=1 toggles the running register.
- Prescaler:
  - counts 0..PULSE_MAX only while running; wraps to 0.
  - cleared to 0 whenever stopped, so each start gives a full first period.
- Tick = prescaler at PULSE_MAX while running. On tick:
  - hundredths +1 mod 10;
  - carry ripples to tenths, then seconds, then tens;
  - 99.99 → 00.00, with no overflow flag.
- While stopped with `increm_i`=1 and `state_value_i` in 1..4:
  - only the addressed digit increments, mod 10 (9→0);
  - no carry into neighbouring digits.
- `increm_i` is ignored in either of these cases:
  - running;
  - `state_value_i` is 0 or 5–7.
- `clear_i` while stopped: all digits → 0. Ignored while running.
- Simultaneous events, all judged against the running register value before the edge:
  - `clear_i` and `increm_i` while stopped: clear wins.
  - `start_stop_i` and `increm_i` while stopped: the increment applies, and running becomes 1 at the same edge.
  - `start_stop_i` on the cycle a tick would occur: the tick still applies, then counting stops.
- Reset asserted mid-count returns every register to its reset value immediately.

## Timing
- `start_stop_i` high at edge N → `device_running_o` changes after edge N, i.e. visible from cycle N+1.
- First tick after start: PULSE_MAX+1 cycles after the starting edge. Subsequent ticks every PULSE_MAX+1 cycles.
- Digit updates are registered, one cycle after the tick/increment/clear qualifier. All carries resolve within that same edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `stopwatch_pkg`:
  - state encodings (IDLE=0, CH_HUND=1, CH_TENTHS=2, CH_SEC=3, CH_TEN=4), reused by the setting FSM;
  - BCD digit width (4);
  - default PULSE_MAX.
- Sub-module `bcd_digit`, instantiated four times:
  - 4-bit mod-10 counter with `en_i`, `clr_i`, and a combinational `carry_o` (= en & value==9).
  - Carry chain: each digit's enable = tick-carry from the lower digit OR (stopped & increment & selected).

## Test plan
- Reset with PULSE_MAX=3: all digits 0 and `device_running_o`=0. Pulse start → running=1 next cycle; after 4 cycles hund=1, after 40 cycles tenths=1, hund=0.
- Preload 9,9,9,9 via increments, start, one tick → all digits 0, running stays 1.
- Stopped, `state_value_i`=3, ten `increm_i` pulses → sec steps 1..9, then 0; other digits unchanged, no carry into tens.
- Running, `increm_i` with state 2 → tenths unaffected. Stopped, `increm_i` with state 0 or 6 → no digit changes.
- Stopped, `clear_i` and `increm_i` (state 1) in the same cycle → all digits 0. `clear_i` while running → ignored.
- Assert `rstn_i` low mid-count → digits, prescaler and running go 0 asynchronously. After release, the first tick needs a full PULSE_MAX+1 cycles after start.
